// File: rtl/dmac_pkg.sv
// Shared DMA controller types: command payload bundle and scheduler state.
package dmac_pkg;

    localparam int DMAC_ADDR_WD = 32;
    localparam int CMD_BURST_WD = 2;
    localparam int CMD_SIZE_WD  = 3;

    typedef struct packed {
        logic [DMAC_ADDR_WD-1:0] src_addr;
        logic [DMAC_ADDR_WD-1:0] dst_addr;
        logic [CMD_BURST_WD-1:0] burst;
        logic [DMAC_ADDR_WD-1:0] len;
        logic [CMD_SIZE_WD-1:0]  size;
    } dmac_cmd_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_e;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module dmac_rr_arbiter #(
    parameter  int CHANNEL_COUNT = 8,
    localparam int CH_ID_WD      = $clog2(CHANNEL_COUNT)
) (
    input  logic [CHANNEL_COUNT-1:0] req,
    input  logic [CH_ID_WD-1:0]      ptr,
    output logic [CHANNEL_COUNT-1:0] gnt_onehot,
    output logic [CH_ID_WD-1:0]      gnt_id,
    output logic                     gnt_any
);

    logic [CH_ID_WD-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        idx        = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            idx = CH_ID_WD'((int'(ptr) + k) % CHANNEL_COUNT);
            if (!gnt_any && req[idx]) begin
                gnt_any         = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = idx;
            end
        end
    end

endmodule

// File: rtl/dmac_cmd_arbiter.sv
// Round-robin scheduler of per-channel DMA commands onto the read cmd port.
// Optional DMAC_CMD_ARB_ERR_EN adds a sticky spurious-done error flag.
module dmac_cmd_arbiter
    import dmac_pkg::*;
#(
    parameter  int ADDR_WD       = 32,
    parameter  int CHANNEL_COUNT = 8,
    localparam int CH_ID_WD      = $clog2(CHANNEL_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNEL_COUNT-1:0]   ch_cmd_valid,
    output logic [CHANNEL_COUNT-1:0]   ch_cmd_ready,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_cmd_src_addr,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_cmd_dst_addr,
    input  logic [CHANNEL_COUNT*2-1:0] ch_cmd_burst,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_cmd_len,
    input  logic [CHANNEL_COUNT*3-1:0] ch_cmd_size,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [ADDR_WD-1:0]         cmd_src_addr,
    output logic [ADDR_WD-1:0]         cmd_dst_addr,
    output logic [1:0]                 cmd_burst,
    output logic [ADDR_WD-1:0]         cmd_len,
    output logic [2:0]                 cmd_size,
    output logic [CH_ID_WD-1:0]        cmd_ch_id,
    input  logic                       done_valid,
    input  logic [CH_ID_WD-1:0]        done_ch_id,
    output logic [CHANNEL_COUNT-1:0]   ch_busy
`ifdef DMAC_CMD_ARB_ERR_EN
    ,
    output logic                       err_spurious_done
`endif
);

    arb_state_e                 state_q, state_d;
    logic [CH_ID_WD-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_ID_WD-1:0]        id_q, id_d;
    dmac_cmd_t                  cmd_q, cmd_d;
    logic [CHANNEL_COUNT-1:0]   busy_q, busy_d;
    logic [CHANNEL_COUNT-1:0]   busy_set, busy_clr;
    logic [CHANNEL_COUNT-1:0]   elig;
    logic [CHANNEL_COUNT-1:0]   gnt_onehot;
    logic [CH_ID_WD-1:0]        gnt_id;
    logic                       gnt_any;
    dmac_cmd_t                  sel;

    assign elig = ch_cmd_valid & ~busy_q;

    dmac_rr_arbiter #(
        .CHANNEL_COUNT(CHANNEL_COUNT)
    ) u_rr (
        .req       (elig),
        .ptr       (rr_ptr_q),
        .gnt_onehot(gnt_onehot),
        .gnt_id    (gnt_id),
        .gnt_any   (gnt_any)
    );

    // AND-OR payload mux keyed by the one-hot grant
    always_comb begin
        sel = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (gnt_onehot[i]) begin
                sel.src_addr = sel.src_addr | ch_cmd_src_addr[i*ADDR_WD +: ADDR_WD];
                sel.dst_addr = sel.dst_addr | ch_cmd_dst_addr[i*ADDR_WD +: ADDR_WD];
                sel.burst    = sel.burst | ch_cmd_burst[i*2 +: 2];
                sel.len      = sel.len | ch_cmd_len[i*ADDR_WD +: ADDR_WD];
                sel.size     = sel.size | ch_cmd_size[i*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        cmd_d        = cmd_q;
        busy_set     = '0;
        ch_cmd_ready = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_any) begin
                    cmd_d   = sel;
                    id_d    = gnt_id;
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (cmd_ready) begin
                    ch_cmd_ready[id_q] = 1'b1;
                    busy_set[id_q]     = 1'b1;
                    rr_ptr_d = (int'(id_q) == CHANNEL_COUNT - 1) ?
                               '0 : id_q + CH_ID_WD'(1);
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Only a done for a currently busy, in-range channel clears anything
    always_comb begin
        busy_clr = '0;
        if (done_valid && (int'(done_ch_id) < CHANNEL_COUNT)) begin
            if (busy_q[done_ch_id]) begin
                busy_clr[done_ch_id] = 1'b1;
            end
        end
        busy_d = (busy_q | busy_set) & ~busy_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            cmd_q    <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
        end
    end

`ifdef DMAC_CMD_ARB_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (done_valid & ~(|busy_clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_spurious_done = err_q;
`endif

    assign cmd_valid    = (state_q == ARB_HOLD);
    assign cmd_src_addr = cmd_q.src_addr;
    assign cmd_dst_addr = cmd_q.dst_addr;
    assign cmd_burst    = cmd_q.burst;
    assign cmd_len      = cmd_q.len;
    assign cmd_size     = cmd_q.size;
    assign cmd_ch_id    = id_q;
    assign ch_busy      = busy_q;

endmodule

// File: doc/dmac_cmd_arbiter.md
Name: dmac_cmd_arbiter

Overview:
- Round-robin scheduler that shares the single DMA read-request generator command port among CHANNEL_COUNT channel command sources.
- Each channel may have at most one command outstanding. A channel is busy from command acceptance until the write side reports completion for that channel ID.
- Presents one registered, stable command at a time on a valid/ready interface that matches the request generator's cmd port.

Parameters:
ADDR_WD, 32, address and length width
CHANNEL_COUNT, 8, number of requesting channels (>=2)
CH_ID_WD, $clog2(CHANNEL_COUNT) (localparam), channel ID width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ch_cmd_valid  input  CHANNEL_COUNT  per-channel command request
ch_cmd_ready  output  CHANNEL_COUNT  per-channel accept pulse
ch_cmd_src_addr  input  CHANNEL_COUNT*ADDR_WD  packed source addresses, channel i at [i*ADDR_WD +: ADDR_WD]
ch_cmd_dst_addr  input  CHANNEL_COUNT*ADDR_WD  packed destination addresses
ch_cmd_burst  input  CHANNEL_COUNT*2  packed AXI burst type
ch_cmd_len  input  CHANNEL_COUNT*ADDR_WD  packed transfer length in bytes
ch_cmd_size  input  CHANNEL_COUNT*3  packed AXI size
cmd_valid  output  1  command to request generator
cmd_ready  input  1  request generator accepts
cmd_src_addr  output  ADDR_WD  granted source address
cmd_dst_addr  output  ADDR_WD  granted destination address
cmd_burst  output  2  granted burst
cmd_len  output  ADDR_WD  granted length
cmd_size  output  3  granted size
cmd_ch_id  output  CH_ID_WD  granted channel ID
done_valid  input  1  completion strobe from write side, 1 cycle
done_ch_id  input  CH_ID_WD  completed channel
ch_busy  output  CHANNEL_COUNT  channel has an outstanding command

Behaviour:
- Interface (already decided): one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - cmd_valid=0, ch_cmd_ready=0, ch_busy=0.
  - All cmd_* payload registers and cmd_ch_id = 0.
- Eligibility: elig[i] = ch_cmd_valid[i] & ~ch_busy[i].
- FSM IDLE:
  - If any elig, pick the winner: the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo CHANNEL_COUNT.
  - Register the winner's payload and ID, set cmd_valid=1, go to HOLD.
  - The command therefore appears 1 cycle after the channel's valid is seen.
- FSM HOLD:
  - cmd_valid=1; payload and cmd_ch_id stay stable.
  - No re-arbitration, even if a higher-priority channel becomes eligible.
  - On cmd_valid & cmd_ready:
    - ch_cmd_ready[cmd_ch_id]=1 in the same cycle (combinational one-hot, all other bits 0).
    - Next cycle: ch_busy[cmd_ch_id]=1, rr_ptr = cmd_ch_id+1 (wraps to 0 past CHANNEL_COUNT-1), cmd_valid=0, state=IDLE.
- Throughput: at most 1 command per 2 cycles (the IDLE cycle is mandatory).
- Channels must hold ch_cmd_valid and payload stable until their ch_cmd_ready. If a channel drops valid during HOLD, the granted command is still issued.
- Completion:
  - done_valid with ch_busy[done_ch_id]=1 clears that busy bit next cycle.
  - done_valid for a non-busy channel, or done_ch_id >= CHANNEL_COUNT, is ignored.
- Simultaneous events:
  - Busy-set for channel A and done-clear for channel B in the same cycle both take effect.
  - The same channel cannot be both set and cleared in one cycle, since busy channels are ineligible.
  - A done in cycle N makes the channel eligible for the IDLE decision in cycle N+1.
- All channels busy, or no valid: stay in IDLE with cmd_valid=0.
- Reset asserted mid-HOLD: everything returns to reset values immediately. The lost command is re-requested by the channel after reset.

Optional Feature:
- Macro: DMAC_CMD_ARB_ERR_EN.
- Defined:
  - Adds output err_spurious_done (1 bit), a sticky flag that is set the cycle after a done_valid arrives for a non-busy or out-of-range channel.
  - Cleared only by reset. Reset value 0.
- Undefined: port absent; spurious done is silently ignored.

Decomposition:
- Add to dmac_pkg:
  - typedef dmac_cmd_t struct {src_addr, dst_addr, burst[1:0], len, size[2:0]}, parameterised by a package constant DMAC_ADDR_WD=32.
  - Constant CMD_BURST_WD=2 and CMD_SIZE_WD=3.
- Sub-module dmac_rr_arbiter: combinational round-robin pick.
  - Ports: req[CHANNEL_COUNT], ptr, gnt_onehot, gnt_id, gnt_any.
  - Reused later for the write-side scheduler.

Test Plan:
- Single channel: ch3 valid, cmd_ready=1 -> cmd_valid 1 cycle later with ch3 payload, cmd_ch_id=3, ch_cmd_ready[3] pulses once, ch_busy=8'h08.
- All 8 channels valid, cmd_ready=1, done returned 2 cycles after each accept -> grant order 0,1,...,7,0 and each accept spaced exactly 2 cycles.
- cmd_ready held 0 for 10 cycles while ch5 is in HOLD and ch1 raises valid -> payload and cmd_ch_id=5 stable throughout; ch1 granted only after ch5 accepts.
- ch2 busy with ch2 valid again -> no grant to ch2; done_valid with done_ch_id=2 -> ch2 regranted and issued 2 cycles later.
- Spurious done_ch_id=6 while ch6 idle -> ch_busy unchanged; with DMAC_CMD_ARB_ERR_EN, err_spurious_done=1 next cycle and sticky.
- rst_n pulsed low during HOLD -> cmd_valid=0, ch_busy=0, rr_ptr=0 immediately; after release, lowest eligible index wins first.
